dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data-memory RAM between the multicycle CPU core and a host/loader port used for preloading matrices and reading back results. It accepts one word request per cycle, issues it to the RAM on registered outputs, and routes synchronous read data back to the winning requester. CPU has default priority, with a starvation guard for the host, an exclusive host lock, and a CPU stall counter for performance reporting.

## Interface
- ADDR_W, 32, word-index width (RAM `index`)
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, consecutive host wait cycles before the host is forced to win; legal range 1..255
- CLOCK_50  in  1  system clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- cpu_req / host_req  in  1  request valid; held until the matching gnt
- cpu_we / host_we  in  1  1 = write, 0 = read
- cpu_addr / host_addr  in  ADDR_W  word index
- cpu_wdata / host_wdata  in  DATA_W  write data
- cpu_gnt / host_gnt  out  1  combinational accept; request taken at the posedge where req&gnt
- cpu_rvalid / host_rvalid  out  1  registered; read data valid for one cycle
- cpu_rdata / host_rdata  out  DATA_W  equal to mem_rdata (pass-through, qualified by rvalid)
- host_lock  in  1  while high, CPU is never granted
- mem_wr_en  out  1  RAM write enable, registered
- mem_index  out  ADDR_W  RAM index, registered
- mem_entry  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read port; valid one cycle after mem_index is sampled
- cpu_stall_cnt  out  32  cycles with cpu_req & !cpu_gnt, saturating

## Operation
- Priority FSM, two states. PRI_CPU (reset state): cpu_gnt = cpu_req & !host_lock; host_gnt = host_req & !cpu_gnt. PRI_HOST: host_gnt = host_req; cpu_gnt = cpu_req & !host_req & !host_lock.
- host_wait (8-bit):
  - Clears on a host grant, or when host_req is low.
  - Otherwise increments each cycle host_req is high and host_gnt is low.
- PRI_CPU → PRI_HOST in the cycle after host_wait reaches STARVE_LIMIT.
- PRI_HOST → PRI_CPU after exactly one host grant, or if host_req drops.
- At most one grant per cycle, and never both.
- Issue stage: on an accepted request, mem_index/mem_entry/mem_wr_en load the winner's addr/wdata/we at that posedge. With no accept, mem_wr_en loads 0, and mem_index/mem_entry hold their values.
- Return tracking: a 2-stage owner pipeline (valid, is_cpu, is_read).
  - Stage 1 loads with the accept.
  - Stage 2 follows one cycle later.
  - rvalid of the owner = stage-2 valid & is_read.
- Writes produce no rvalid.
- Back-to-back requests from either side are accepted every cycle. Read-after-write to the same address returns the new data, because the RAM write precedes the later read index.
- cpu_stall_cnt increments each cycle cpu_req & !cpu_gnt (including lock cycles) and holds at 32'hFFFF_FFFF.
- Reset mid-operation: in-flight reads are discarded, with no rvalid after rst. A pending write already on mem_wr_en completes in the rst cycle; only the next mem_wr_en value is forced to 0.

## Timing
- Reset values: mem_wr_en 0, mem_index 0, mem_entry 0, cpu_rvalid/host_rvalid 0, cpu_stall_cnt 0, FSM PRI_CPU, host_wait 0, owner pipeline invalid. cpu_gnt/host_gnt are forced 0 while rst is high.
- Cycle T: req&gnt accepted.
- T+1: mem_* drive the request.
- T+2: rvalid high and rdata valid, for reads.
- Read latency is 2 cycles from the accepting edge. Throughput is 1 request/cycle total.
- Worst-case host wait with CPU requesting every cycle: STARVE_LIMIT+1 cycles.
- host_lock takes effect on gnt in the same cycle (combinational). An in-flight CPU read still returns its rvalid.
- A requester must keep req/we/addr/wdata stable until gnt. After an accepted request it may drop req, or present a new request, in the next cycle.

## Test plan
- Single CPU write of 32'hDEADBEEF to index 5 at T, then a read at T+1 → at T+1 mem_wr_en=1, mem_index=5; cpu_rvalid at T+3 with cpu_rdata=32'hDEADBEEF; host_rvalid stays 0.
- Both request continuously, STARVE_LIMIT=4 → grant pattern CPU×4, HOST, CPU×4, HOST…; cpu_stall_cnt increments by 1 per host grant.
- host_lock=1 with cpu_req held for 10 cycles and host idle → cpu_gnt=0 throughout, cpu_stall_cnt=10. Release lock → cpu_gnt=1 the same cycle.
- Host back-to-back reads of indices 0..7 while the CPU is idle → 8 consecutive host_rvalid pulses starting 2 cycles after the first grant, data in address order.
- Assert rst one cycle after a CPU read is accepted → no cpu_rvalid; all outputs at reset values the cycle after rst; first request after rst deasserts is granted with normal latency.
- Drive cpu_stall_cnt preset near saturation (force to 32'hFFFF_FFFE, stall 3 cycles) → reads 32'hFFFF_FFFF and holds.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU core and the host loader; CPU wins by default, host is starvation-guarded.
// Read data returns 2 cycles after the accepting edge; a loser sees gnt low and simply holds its request.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,

  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_entry,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [31:0]       cpu_stall_cnt
);

  typedef enum logic {
    PRI_CPU  = 1'b0,
    PRI_HOST = 1'b1
  } pri_t;

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  pri_t       pri;
  logic [7:0] host_wait;
  logic [7:0] host_wait_nxt;
  logic       cpu_win_cpu_pri;

  // Return-owner pipeline: stage 1 tracks the RAM issue cycle, stage 2 the data cycle.
  logic s1_vld, s1_cpu, s1_rd;
  logic s2_vld, s2_cpu, s2_rd;

  assign cpu_win_cpu_pri = cpu_req & ~host_lock;

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (pri == PRI_CPU) begin
        cpu_gnt  = cpu_win_cpu_pri;
        host_gnt = host_req & ~cpu_win_cpu_pri;
      end else begin
        host_gnt = host_req;
        cpu_gnt  = cpu_req & ~host_req & ~host_lock;
      end
    end
  end

  always_comb begin
    host_wait_nxt = host_wait;
    if (host_gnt || !host_req)
      host_wait_nxt = 8'd0;
    else if (host_wait != 8'hFF)
      host_wait_nxt = host_wait + 8'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pri           <= PRI_CPU;
      host_wait     <= 8'd0;
      mem_wr_en     <= 1'b0;
      mem_index     <= '0;
      mem_entry     <= '0;
      s1_vld        <= 1'b0;
      s1_cpu        <= 1'b0;
      s1_rd         <= 1'b0;
      s2_vld        <= 1'b0;
      s2_cpu        <= 1'b0;
      s2_rd         <= 1'b0;
      cpu_stall_cnt <= 32'd0;
    end else begin
      host_wait <= host_wait_nxt;

      // Switching on the next wait value lets the host win on the cycle right after the limit is hit.
      if (pri == PRI_CPU) begin
        if (host_wait_nxt >= STARVE_LIM8)
          pri <= PRI_HOST;
      end else if (host_gnt || !host_req) begin
        pri <= PRI_CPU;
      end

      mem_wr_en <= 1'b0;
      if (cpu_gnt) begin
        mem_wr_en <= cpu_we;
        mem_index <= cpu_addr;
        mem_entry <= cpu_wdata;
      end else if (host_gnt) begin
        mem_wr_en <= host_we;
        mem_index <= host_addr;
        mem_entry <= host_wdata;
      end

      s1_vld <= cpu_gnt | host_gnt;
      s1_cpu <= cpu_gnt;
      s1_rd  <= cpu_gnt ? ~cpu_we : ~host_we;
      s2_vld <= s1_vld;
      s2_cpu <= s1_cpu;
      s2_rd  <= s1_rd;

      if (cpu_req && !cpu_gnt && cpu_stall_cnt != 32'hFFFF_FFFF)
        cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
    end
  end

  assign cpu_rvalid  = s2_vld &  s2_cpu & s2_rd;
  assign host_rvalid = s2_vld & ~s2_cpu & s2_rd;
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table-driven grant vectors, a behavioural RAM, and a read-return scoreboard.
module tb_dmem_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_gnt, host_gnt, cpu_rvalid, host_rvalid;
  logic [31:0] cpu_rdata, host_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_index, mem_entry, mem_rdata;
  logic [31:0] cpu_stall_cnt;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock),
    .mem_wr_en(mem_wr_en), .mem_index(mem_index), .mem_entry(mem_entry), .mem_rdata(mem_rdata),
    .cpu_stall_cnt(cpu_stall_cnt)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous single-port RAM, read-first.
  logic [31:0] ram [256];
  always @(posedge CLOCK_50) begin
    if (mem_wr_en) ram[mem_index[7:0]] <= mem_entry;
    mem_rdata <= ram[mem_index[7:0]];
  end

  typedef struct {
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic        host_lock;
    logic        exp_cpu_gnt, exp_host_gnt;
  } vec_t;

  typedef struct {
    logic        is_cpu;
    logic [31:0] data;
    int          due;
  } rd_t;

  vec_t        tbl[$];
  rd_t         sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        m_we;
  logic [31:0] m_idx, m_ent, m_stall;
  logic [31:0] shadow [256];

  function automatic vec_t mk(input logic r, cr, cw, input logic [31:0] ca, cd,
                              input logic hr, hw, input logic [31:0] ha, hd,
                              input logic lk, ecg, ehg);
    vec_t v;
    v.rst = r;  v.cpu_req = cr;  v.cpu_we = cw;  v.cpu_addr = ca;  v.cpu_wdata = cd;
    v.host_req = hr;  v.host_we = hw;  v.host_addr = ha;  v.host_wdata = hd;
    v.host_lock = lk;  v.exp_cpu_gnt = ecg;  v.exp_host_gnt = ehg;
    return v;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_rv();
    rd_t         e;
    logic        ec, eh;
    logic [31:0] ed, got;
    ec = 1'b0; eh = 1'b0; ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e  = sbq.pop_front();
      ec = e.is_cpu;
      eh = !e.is_cpu;
      ed = e.data;
    end
    checks++;
    if (cpu_rvalid !== ec || host_rvalid !== eh) begin
      failures++;
      $display("FAIL rvalid cyc=%0d cpu_rvalid=%b host_rvalid=%b required %b %b",
               cyc, cpu_rvalid, host_rvalid, ec, eh);
    end
    if (ec || eh) begin
      got = ec ? cpu_rdata : host_rdata;
      chk32(ec ? "cpu_rdata" : "host_rdata", got, ed);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    cyc++;
    check_rv();
  endtask

  task automatic accept(input logic is_cpu, input logic we, input logic [31:0] a, input logic [31:0] d);
    rd_t e;
    m_we = we; m_idx = a; m_ent = d;
    if (we) shadow[a[7:0]] = d;
    else begin
      e.is_cpu = is_cpu; e.data = shadow[a[7:0]]; e.due = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    cpu_req = v.cpu_req;   cpu_we = v.cpu_we;   cpu_addr = v.cpu_addr;   cpu_wdata = v.cpu_wdata;
    host_req = v.host_req; host_we = v.host_we; host_addr = v.host_addr; host_wdata = v.host_wdata;
    host_lock = v.host_lock;
    #1;
    checks++;
    if (cpu_gnt !== v.exp_cpu_gnt || host_gnt !== v.exp_host_gnt) begin
      failures++;
      $display("FAIL gnt cyc=%0d cpu_gnt=%b host_gnt=%b required %b %b",
               cyc, cpu_gnt, host_gnt, v.exp_cpu_gnt, v.exp_host_gnt);
    end
    if (v.rst) begin
      sbq.delete();
      m_we = 1'b0; m_idx = '0; m_ent = '0; m_stall = '0;
    end else begin
      if (v.cpu_req && !v.exp_cpu_gnt && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (v.exp_cpu_gnt) accept(1'b1, v.cpu_we, v.cpu_addr, v.cpu_wdata);
      else if (v.exp_host_gnt) accept(1'b0, v.host_we, v.host_addr, v.host_wdata);
      else m_we = 1'b0;
    end
    tick();
    chk32("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, m_we});
    chk32("mem_index", mem_index, m_idx);
    chk32("mem_entry", mem_entry, m_ent);
    chk32("cpu_stall_cnt", cpu_stall_cnt, m_stall);
  endtask

  vec_t idle, both;

  initial begin
    m_we = 1'b0; m_idx = '0; m_ent = '0; m_stall = '0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    idle = mk(0, 0,0,0,0, 0,0,0,0, 0, 0,0);
    both = mk(0, 1,0,5,0, 1,0,2,0, 0, 0,0);

    // Reset (grants forced low), CPU write then read-after-write of index 5.
    tbl.push_back(mk(1, 1,0,0,0, 1,0,0,0, 0, 0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 1,1,5,32'hDEAD_BEEF, 0,0,0,0, 0, 1,0));
    tbl.push_back(mk(0, 1,0,5,0, 0,0,0,0, 0, 1,0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    // Host preload of indices 0..7, then back-to-back host reads.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0,0,0,0, 1,1,i,32'hA000_0000 + i, 0, 0,1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0,0,0,0, 1,0,i,0, 0, 0,1));
    tbl.push_back(idle);
    tbl.push_back(idle);
    // Both requesting: CPU x4, HOST, CPU x4, HOST.
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = both;
      v.exp_cpu_gnt  = (i % 5) != 4;
      v.exp_host_gnt = (i % 5) == 4;
      tbl.push_back(v);
    end
    tbl.push_back(idle);
    // Host drops its request while it has priority: CPU must win and priority returns to CPU.
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = both; v.exp_cpu_gnt = 1'b1;
      tbl.push_back(v);
    end
    tbl.push_back(mk(0, 1,0,5,0, 0,0,0,0, 0, 1,0));
    tbl.push_back(mk(0, 1,0,5,0, 1,0,2,0, 0, 1,0));
    tbl.push_back(idle);
    tbl.push_back(idle);

    foreach (tbl[i]) apply(tbl[i]);

    // Host lock: CPU held off for 10 cycles, released lock grants in the same cycle.
    apply(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0));
    for (int i = 0; i < 10; i++) apply(mk(0, 1,0,3,0, 0,0,0,0, 1, 0,0));
    chk32("stall_after_lock", cpu_stall_cnt, 32'd10);
    apply(mk(0, 1,0,3,0, 0,0,0,0, 0, 1,0));
    apply(mk(0, 1,0,4,0, 1,0,6,0, 1, 0,1));
    apply(idle);
    apply(idle);

    // Reset one cycle after an accepted CPU read: the read never returns.
    apply(mk(0, 1,0,2,0, 0,0,0,0, 0, 1,0));
    apply(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0));
    apply(idle);
    apply(mk(0, 1,0,5,0, 0,0,0,0, 0, 1,0));
    apply(idle);
    apply(idle);

    // A write already on the RAM port when reset hits still lands.
    apply(mk(0, 1,1,20,32'h1234_5678, 0,0,0,0, 0, 1,0));
    apply(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0));
    apply(mk(0, 1,0,20,0, 0,0,0,0, 0, 1,0));
    apply(idle);
    apply(idle);

    // Stall counter saturation from a preset near the top.
    apply(mk(0, 1,0,5,0, 0,0,0,0, 1, 0,0));
    force dut.cpu_stall_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.cpu_stall_cnt;
    tick();
    tick();
    chk32("stall_saturate", cpu_stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk32("stall_hold", cpu_stall_cnt, 32'hFFFF_FFFF);
    m_stall = 32'hFFFF_FFFF;
    apply(mk(0, 1,0,5,0, 0,0,0,0, 1, 0,0));
    apply(mk(0, 1,0,5,0, 0,0,0,0, 0, 1,0));
    apply(idle);
    apply(idle);
    apply(idle);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL pending_reads got=%0d required=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
